// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate enable, x/y counters, sync/blank decode (VGA_FRAME_CNT_EN adds frame_cnt).
// Latency: hsync/vsync registered from next-state counters, so aligned with x/y; video_on/frame_start combinational.
// Backpressure: none, free-running; reset_n (async, active-low) restarts the raster at (0,0).
module vga_sync_gen #(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_RETRACE = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_RETRACE = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;

    localparam logic [9:0] H_MAX      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS      = 10'(V_DISPLAY);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] H_SYNC_END = 10'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] V_SYNC_END = 10'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    logic [9:0] x_next;
    logic [9:0] y_next;

    generate
        if (CLK_DIV == 1) begin : g_nodiv
            assign p_tick = 1'b1;
        end else begin : g_div
            localparam int DIV_W = $clog2(CLK_DIV);
            localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
            logic [DIV_W-1:0] div_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    div_cnt <= '0;
                end else if (div_cnt == DIV_MAX) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            assign p_tick = (div_cnt == DIV_MAX);
        end
    endgenerate

    always_comb begin
        x_next = x;
        y_next = y;
        if (p_tick) begin
            if (x == H_MAX) begin
                x_next = '0;
                y_next = (y == V_MAX) ? 10'd0 : y + 10'd1;
            end else begin
                x_next = x + 10'd1;
            end
        end
    end

    // Syncs decode the next-state counters so they land in the same cycle as x/y.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x     <= '0;
            y     <= '0;
            hsync <= ~SYNC_POL;
            vsync <= ~SYNC_POL;
        end else begin
            x     <= x_next;
            y     <= y_next;
            hsync <= (x_next >= H_SYNC_BEG && x_next <= H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
            vsync <= (y_next >= V_SYNC_BEG && y_next <= V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign video_on    = (x < H_VIS) && (y < V_VIS);
    assign frame_start = p_tick && (x == H_MAX) && (y == V_MAX);

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (12x8 total, 6x4 visible) at CLK_DIV=4 and CLK_DIV=1.
// Instance a: active-low syncs; instance b: active-high syncs.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       a_pt, a_hs, a_vs, a_von, a_fs;
    logic [9:0] a_x, a_y;
    logic       b_pt, b_hs, b_vs, b_von, b_fs;
    logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] a_fc, b_fc;
`endif

    vga_sync_gen #(
        .CLK_DIV(4), .H_DISPLAY(6), .H_FRONT(2), .H_RETRACE(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .p_tick(a_pt), .x(a_x), .y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .frame_start(a_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(a_fc)
`endif
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(6), .H_FRONT(2), .H_RETRACE(3), .H_BACK(1),
        .V_DISPLAY(4), .V_FRONT(1), .V_RETRACE(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .p_tick(b_pt), .x(b_x), .y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(b_fc)
`endif
    );

    typedef struct {
        int n;
        int x;
        int y;
        int hs;
        int vs;
        int von;
        int pt;
        int fs;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;
    vec_t tbl[18];
    vec_t exp_q[$];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (clk %0d)", name, act, req, n);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
    endtask

    initial begin
        vec_t e;
        int   cnt_a;
        int   cnt_b;
        bit   found;

        // n = rising edges since reset release; instance a advances one pixel per 4 edges.
        tbl[0]  = '{0,   0,  0, 1, 1, 1, 0, 0};
        tbl[1]  = '{3,   0,  0, 1, 1, 1, 1, 0};
        tbl[2]  = '{4,   1,  0, 1, 1, 1, 0, 0};
        tbl[3]  = '{23,  5,  0, 1, 1, 1, 1, 0};
        tbl[4]  = '{24,  6,  0, 1, 1, 0, 0, 0};
        tbl[5]  = '{31,  7,  0, 1, 1, 0, 1, 0};
        tbl[6]  = '{32,  8,  0, 0, 1, 0, 0, 0};
        tbl[7]  = '{43,  10, 0, 0, 1, 0, 1, 0};
        tbl[8]  = '{44,  11, 0, 1, 1, 0, 0, 0};
        tbl[9]  = '{47,  11, 0, 1, 1, 0, 1, 0};
        tbl[10] = '{48,  0,  1, 1, 1, 1, 0, 0};
        tbl[11] = '{188, 11, 3, 1, 1, 0, 0, 0};
        tbl[12] = '{192, 0,  4, 1, 1, 0, 0, 0};
        tbl[13] = '{240, 0,  5, 1, 0, 0, 0, 0};
        tbl[14] = '{288, 0,  6, 1, 0, 0, 0, 0};
        tbl[15] = '{336, 0,  7, 1, 1, 0, 0, 0};
        tbl[16] = '{383, 11, 7, 1, 1, 0, 1, 1};
        tbl[17] = '{384, 0,  0, 1, 1, 1, 0, 0};

        repeat (3) @(negedge clk);
        release_reset();

        for (int i = 0; i < 18; i++) begin
            exp_q.push_back(tbl[i]);
            while (n < tbl[i].n) tick();
            e = exp_q.pop_front();
            check("a_x",           a_x,   e.x);
            check("a_y",           a_y,   e.y);
            check("a_hsync",       a_hs,  e.hs);
            check("a_vsync",       a_vs,  e.vs);
            check("a_video_on",    a_von, e.von);
            check("a_p_tick",      a_pt,  e.pt);
            check("a_frame_start", a_fs,  e.fs);
        end

        // Frame pulse rate: a frames are 384 clks, b frames 96 clks.
        cnt_a = 0;
        cnt_b = 0;
        while (n < 1536) begin
            tick();
            if (a_fs) cnt_a++;
            if (b_fs) cnt_b++;
            check("b_p_tick_const", b_pt, 1);
        end
        check("a_frame_start_count", cnt_a, 3);
        check("b_frame_start_count", cnt_b, 12);

        // Reset mid-cycle while a is inside its hsync pulse.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            tick();
            if (a_x == 10'd9 && a_pt) found = 1'b1;
        end
        check("reach_mid_hsync", int'(found), 1);
        check("a_hsync_pre_reset", a_hs, 0);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_a_x",     a_x,  0);
        check("rst_a_y",     a_y,  0);
        check("rst_a_hsync", a_hs, 1);
        check("rst_a_vsync", a_vs, 1);
        check("rst_a_p_tick", a_pt, 0);
        check("rst_a_frame_start", a_fs, 0);
        check("rst_b_hsync", b_hs, 0);
        check("rst_b_vsync", b_vs, 0);
        release_reset();

        // Restart: a first ticks at edge 3; b walks one full line at one pixel per clk.
        check("b_x_restart", b_x, 0);
        check("b_p_tick_restart", b_pt, 1);
        for (int i = 1; i <= 12; i++) begin
            int ex;
            tick();
            ex = n % 12;
            check("b_x",        b_x,  ex);
            check("b_y",        b_y,  n / 12);
            check("b_hsync",    b_hs, (ex >= 8 && ex <= 10) ? 1 : 0);
            check("b_vsync",    b_vs, 0);
            check("b_video_on", b_von, (ex < 6 && n / 12 < 4) ? 1 : 0);
            check("b_p_tick",   b_pt, 1);
            if (n == 2) check("a_p_tick_restart_low", a_pt, 0);
            if (n == 3) check("a_p_tick_restart_high", a_pt, 1);
            if (n == 4) check("a_x_restart", a_x, 1);
        end

`ifdef VGA_FRAME_CNT_EN
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_b_frame_cnt", b_fc, 0);
        release_reset();
        while (n < 255 * 96) tick();
        check("b_frame_cnt_255", b_fc, 255);
        while (n < 256 * 96) tick();
        check("b_frame_cnt_wrap", b_fc, 0);
        while (n < 257 * 96) tick();
        check("b_frame_cnt_end", b_fc, 1);
        check("a_frame_cnt_end", a_fc, 64);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
